// File: rtl/fsk_pkg.sv
// Shared constants, state encoding and sizing helpers for the FSK
// pulse-width encoder and its matching decoder.
package fsk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } fsk_state_t;

    localparam int FSK_ONE_CYCLES     = 4;
    localparam int FSK_ZERO_CYCLES    = 10;
    localparam int FSK_LOW_CYCLES     = 4;
    localparam int FSK_DECODE_THRESH  = 7;
    localparam int FSK_CODEWORD_WIDTH = 7;

    // Counter width for a value range; never narrower than one bit.
    function automatic int fsk_cnt_width(input int max_count);
        return ($clog2(max_count) < 1) ? 1 : $clog2(max_count);
    endfunction

    function automatic int fsk_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/fsk_symbol_timer.sv
// Loadable down-counter that times each high pulse and low gap.
// It holds at zero; a load always takes priority over counting.
module fsk_symbol_timer
    import fsk_pkg::*;
#(
    parameter int TW = fsk_cnt_width(FSK_ZERO_CYCLES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_value,
    output logic          o_zero
);

    logic [TW-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/fsk_encoder.sv
// Serialises a parallel codeword MSB-first as high pulses whose width
// encodes the bit (short = 1, long = 0), each followed by a fixed low gap.
module fsk_encoder
    import fsk_pkg::*;
#(
    parameter int WIDTH         = FSK_CODEWORD_WIDTH,
    parameter int ONE_CYCLES    = FSK_ONE_CYCLES,
    parameter int ZERO_CYCLES   = FSK_ZERO_CYCLES,
    parameter int LOW_CYCLES    = FSK_LOW_CYCLES,
    parameter int DECODE_THRESH = FSK_DECODE_THRESH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             codeout,
    output logic             busy,
    output logic             done
);

    localparam int TW = fsk_cnt_width(fsk_max3(ONE_CYCLES, ZERO_CYCLES, LOW_CYCLES));
    localparam int BW = fsk_cnt_width(WIDTH);

    localparam logic [TW-1:0] ONE_LOAD  = TW'(ONE_CYCLES - 1);
    localparam logic [TW-1:0] ZERO_LOAD = TW'(ZERO_CYCLES - 1);
    localparam logic [TW-1:0] LOW_LOAD  = TW'(LOW_CYCLES - 1);
    localparam logic [BW-1:0] BITS_INIT = BW'(WIDTH - 1);

    // Pulse widths must straddle the decoder threshold and fit its 4-bit counter.
    if (ONE_CYCLES < 1 || ONE_CYCLES >= DECODE_THRESH ||
        ZERO_CYCLES < DECODE_THRESH || ZERO_CYCLES >= 16) begin : g_bad_pulse_timing
        $fatal(1, "fsk_encoder: pulse widths incompatible with decoder threshold");
    end
    if (LOW_CYCLES < 1) begin : g_bad_low_gap
        $fatal(1, "fsk_encoder: LOW_CYCLES must be at least 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "fsk_encoder: WIDTH must be at least 1");
    end

    fsk_state_t       r_state;
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_bits_left;
    logic             r_codeout;
    logic             r_busy;
    logic             r_done;
    logic             r_ready;

    logic             w_accept;
    logic             w_timer_zero;
    logic             w_timer_load;
    logic [TW-1:0]    w_timer_value;

    assign w_accept = data_valid & r_ready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_timer_load  = 1'b0;
        w_timer_value = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_timer_load  = 1'b1;
                    w_timer_value = data_in[WIDTH-1] ? ONE_LOAD : ZERO_LOAD;
                end
            end
            HIGH: begin
                if (w_timer_zero) begin
                    w_timer_load  = 1'b1;
                    w_timer_value = LOW_LOAD;
                end
            end
            LOW: begin
                if (w_timer_zero && r_bits_left != '0) begin
                    w_timer_load  = 1'b1;
                    w_timer_value = r_shift[WIDTH-1] ? ONE_LOAD : ZERO_LOAD;
                end
            end
            default: begin
                w_timer_load  = 1'b0;
                w_timer_value = '0;
            end
        endcase
    end

    fsk_symbol_timer #(
        .TW (TW)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_timer_load),
        .i_load_value (w_timer_value),
        .o_zero       (w_timer_zero)
    );

    // The consumed bit is shifted out as its pulse ends, so the MSB already
    // holds the next bit by the time the low gap finishes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bits_left <= '0;
            r_codeout   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift     <= data_in;
                        r_bits_left <= BITS_INIT;
                        r_state     <= HIGH;
                        r_codeout   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_ready     <= 1'b0;
                    end
                end
                HIGH: begin
                    if (w_timer_zero) begin
                        r_shift   <= r_shift << 1;
                        r_state   <= LOW;
                        r_codeout <= 1'b0;
                    end
                end
                LOW: begin
                    if (w_timer_zero) begin
                        if (r_bits_left != '0) begin
                            r_bits_left <= r_bits_left - 1'b1;
                            r_state     <= HIGH;
                            r_codeout   <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_codeout <= 1'b0;
                    r_busy    <= 1'b0;
                    r_ready   <= 1'b1;
                end
            endcase
        end
    end

    assign data_ready = r_ready;
    assign codeout    = r_codeout;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
